// File: rtl/decode_stage.sv
// decode_stage: single-entry RV32I decode pipeline register with a valid/ready
// handshake, flush, and an optional load-use stall.
// Build option: define LOAD_USE_STALL_EN to enable the load-use stall. When it
// is undefined, stall is tied low and ex_rd / ex_is_load are ignored.
module decode_stage #(
   parameter logic [31:0] NOP_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        if_valid,
   input  logic [31:0] if_instr,
   input  logic [31:0] if_pc,
   output logic        id_ready,
   input  logic        flush,
   input  logic        ex_ready,
   input  logic [4:0]  ex_rd,
   input  logic        ex_is_load,
   output logic        id_valid,
   output logic [31:0] id_pc,
   output logic [4:0]  id_rs1,
   output logic [4:0]  id_rs2,
   output logic [4:0]  id_rd,
   output logic [31:0] id_imm,
   output logic [3:0]  id_op,
   output logic        id_reg_write,
   output logic        id_illegal
);

   localparam logic [3:0] OpR       = 4'd0;
   localparam logic [3:0] OpIAlu    = 4'd1;
   localparam logic [3:0] OpLoad    = 4'd2;
   localparam logic [3:0] OpStore   = 4'd3;
   localparam logic [3:0] OpBranch  = 4'd4;
   localparam logic [3:0] OpJal     = 4'd5;
   localparam logic [3:0] OpJalr    = 4'd6;
   localparam logic [3:0] OpLui     = 4'd7;
   localparam logic [3:0] OpAuipc   = 4'd8;
   localparam logic [3:0] OpIllegal = 4'd15;

   // Decoded fields of if_instr
   logic [3:0]  dec_op;
   logic [31:0] dec_imm;
   logic [4:0]  dec_rd;
   logic        dec_writes;
   logic        dec_use_rs1;
   logic        dec_use_rs2;

   // Held pipeline register
   logic        held_q, held_d;
   logic [31:0] pc_q;
   logic [4:0]  rs1_q, rs2_q, rd_q;
   logic [31:0] imm_q;
   logic [3:0]  op_q;
   logic        reg_write_q;
   logic        illegal_q;
   logic        use_rs1_q, use_rs2_q;

   logic        stall;
   logic        accept;
   logic        handoff;

   // Combinational RV32I decode of the incoming instruction word
   always_comb begin
      dec_op      = OpIllegal;
      dec_imm     = 32'h0;
      dec_rd      = if_instr[11:7];
      dec_writes  = 1'b0;
      dec_use_rs1 = 1'b0;
      dec_use_rs2 = 1'b0;
      case (if_instr[6:0])
         7'b0110011: begin
            dec_op      = OpR;
            dec_writes  = 1'b1;
            dec_use_rs1 = 1'b1;
            dec_use_rs2 = 1'b1;
         end
         7'b0010011: begin
            dec_op      = OpIAlu;
            dec_imm     = {{20{if_instr[31]}}, if_instr[31:20]};
            dec_writes  = 1'b1;
            dec_use_rs1 = 1'b1;
         end
         7'b0000011: begin
            dec_op      = OpLoad;
            dec_imm     = {{20{if_instr[31]}}, if_instr[31:20]};
            dec_writes  = 1'b1;
            dec_use_rs1 = 1'b1;
         end
         7'b0100011: begin
            dec_op      = OpStore;
            dec_imm     = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
            dec_rd      = 5'd0;
            dec_use_rs1 = 1'b1;
            dec_use_rs2 = 1'b1;
         end
         7'b1100011: begin
            dec_op      = OpBranch;
            dec_imm     = {{19{if_instr[31]}}, if_instr[31], if_instr[7], if_instr[30:25],
                           if_instr[11:8], 1'b0};
            dec_rd      = 5'd0;
            dec_use_rs1 = 1'b1;
            dec_use_rs2 = 1'b1;
         end
         7'b1101111: begin
            dec_op     = OpJal;
            dec_imm    = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12], if_instr[20],
                          if_instr[30:21], 1'b0};
            dec_writes = 1'b1;
         end
         7'b1100111: begin
            dec_op      = OpJalr;
            dec_imm     = {{20{if_instr[31]}}, if_instr[31:20]};
            dec_writes  = 1'b1;
            dec_use_rs1 = 1'b1;
         end
         7'b0110111: begin
            dec_op     = OpLui;
            dec_imm    = {if_instr[31:12], 12'h000};
            dec_writes = 1'b1;
         end
         7'b0010111: begin
            dec_op     = OpAuipc;
            dec_imm    = {if_instr[31:12], 12'h000};
            dec_writes = 1'b1;
         end
         default: begin
            dec_op = OpIllegal;
            dec_rd = 5'd0;
         end
      endcase
   end

   // Load-use hazard against the instruction in EX; only operands the held
   // instruction actually reads can trigger it.
`ifdef LOAD_USE_STALL_EN
   always_comb begin
      stall = held_q && ex_is_load && (ex_rd != 5'd0) &&
              ((use_rs1_q && (rs1_q == ex_rd)) || (use_rs2_q && (rs2_q == ex_rd)));
   end
`else
   always_comb begin
      stall = 1'b0;
   end
`endif

   // Handshake and next held state; flush outranks accept
   always_comb begin
      id_ready = !flush && !stall && (!held_q || ex_ready);
      id_valid = held_q && !stall;
      accept   = if_valid && id_ready;
      handoff  = id_valid && ex_ready;
      held_d   = held_q;
      if (flush) begin
         held_d = 1'b0;
      end else if (accept) begin
         held_d = 1'b1;
      end else if (handoff) begin
         held_d = 1'b0;
      end
   end

   // Pipeline register; contents only change on accept so stalls and
   // backpressure keep the outputs frozen.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         held_q      <= 1'b0;
         pc_q        <= NOP_PC;
         rs1_q       <= 5'd0;
         rs2_q       <= 5'd0;
         rd_q        <= 5'd0;
         imm_q       <= 32'h0;
         op_q        <= 4'd0;
         reg_write_q <= 1'b0;
         illegal_q   <= 1'b0;
         use_rs1_q   <= 1'b0;
         use_rs2_q   <= 1'b0;
      end else begin
         held_q <= held_d;
         if (!flush && accept) begin
            pc_q        <= if_pc;
            rs1_q       <= if_instr[19:15];
            rs2_q       <= if_instr[24:20];
            rd_q        <= dec_rd;
            imm_q       <= dec_imm;
            op_q        <= dec_op;
            reg_write_q <= dec_writes && (dec_rd != 5'd0);
            illegal_q   <= (dec_op == OpIllegal);
            use_rs1_q   <= dec_use_rs1;
            use_rs2_q   <= dec_use_rs2;
         end
      end
   end

   // Registered outputs
   always_comb begin
      id_pc        = pc_q;
      id_rs1       = rs1_q;
      id_rs2       = rs2_q;
      id_rd        = rd_q;
      id_imm       = imm_q;
      id_op        = op_q;
      id_reg_write = reg_write_q;
      id_illegal   = illegal_q;
   end

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: table-driven decode vectors plus directed handshake,
// flush, stall and reset sequences for decode_stage.
module tb_decode_stage;

`ifdef LOAD_USE_STALL_EN
   localparam bit StallEn = 1'b1;
`else
   localparam bit StallEn = 1'b0;
`endif
   localparam logic [31:0] NopPc = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic        id_ready;
   logic        flush;
   logic        ex_ready;
   logic [4:0]  ex_rd;
   logic        ex_is_load;
   logic        id_valid;
   logic [31:0] id_pc;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic [31:0] id_imm;
   logic [3:0]  id_op;
   logic        id_reg_write;
   logic        id_illegal;

   int checks = 0;
   int failures = 0;

   decode_stage #(.NOP_PC(NopPc)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .if_valid     (if_valid),
      .if_instr     (if_instr),
      .if_pc        (if_pc),
      .id_ready     (id_ready),
      .flush        (flush),
      .ex_ready     (ex_ready),
      .ex_rd        (ex_rd),
      .ex_is_load   (ex_is_load),
      .id_valid     (id_valid),
      .id_pc        (id_pc),
      .id_rs1       (id_rs1),
      .id_rs2       (id_rs2),
      .id_rd        (id_rd),
      .id_imm       (id_imm),
      .id_op        (id_op),
      .id_reg_write (id_reg_write),
      .id_illegal   (id_illegal)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [3:0]  op;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [31:0] imm;
      logic        rw;
      logic        ill;
   } vec_t;

   vec_t vecs[13];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // instr, pc, op, rs1, rs2, rd, imm, reg_write, illegal
      vecs[0]  = '{32'h00708293, 32'h1000, 4'd1,  5'd1,  5'd7,  5'd5,  32'h7,        1'b1, 1'b0};
      vecs[1]  = '{32'hFE21AE23, 32'h1004, 4'd3,  5'd3,  5'd2,  5'd0,  32'hFFFFFFFC, 1'b0, 1'b0};
      vecs[2]  = '{32'hFFFFFFFF, 32'h1008, 4'd15, 5'd31, 5'd31, 5'd0,  32'h0,        1'b0, 1'b1};
      vecs[3]  = '{32'h00228333, 32'h100C, 4'd0,  5'd5,  5'd2,  5'd6,  32'h0,        1'b1, 1'b0};
      vecs[4]  = '{32'h00812503, 32'h1010, 4'd2,  5'd2,  5'd8,  5'd10, 32'h8,        1'b1, 1'b0};
      vecs[5]  = '{32'hFE208CE3, 32'h1014, 4'd4,  5'd1,  5'd2,  5'd0,  32'hFFFFFFF8, 1'b0, 1'b0};
      vecs[6]  = '{32'h010000EF, 32'h1018, 4'd5,  5'd0,  5'd16, 5'd1,  32'h10,       1'b1, 1'b0};
      vecs[7]  = '{32'h123453B7, 32'h101C, 4'd7,  5'd8,  5'd3,  5'd7,  32'h12345000, 1'b1, 1'b0};
      vecs[8]  = '{32'hFFFFF017, 32'h1020, 4'd8,  5'd31, 5'd31, 5'd0,  32'hFFFFF000, 1'b0, 1'b0};
      vecs[9]  = '{32'h00008067, 32'h1024, 4'd6,  5'd1,  5'd0,  5'd0,  32'h0,        1'b0, 1'b0};
      vecs[10] = '{32'h80000013, 32'h1028, 4'd1,  5'd0,  5'd0,  5'd0,  32'hFFFFF800, 1'b0, 1'b0};
      vecs[11] = '{32'h80000FB7, 32'h102C, 4'd7,  5'd0,  5'd0,  5'd31, 32'h80000000, 1'b1, 1'b0};
      vecs[12] = '{32'h00708293, 32'h1030, 4'd1,  5'd1,  5'd7,  5'd5,  32'h7,        1'b1, 1'b0};

      rst_n = 1'b0; if_valid = 1'b0; if_instr = 32'h0; if_pc = 32'h0;
      flush = 1'b0; ex_ready = 1'b0; ex_rd = 5'd0; ex_is_load = 1'b0;

      // Reset state
      step(); step();
      check("rst_valid", {31'b0, id_valid}, 32'd0);
      check("rst_pc", id_pc, NopPc);
      check("rst_op", {28'b0, id_op}, 32'd0);
      check("rst_rd", {27'b0, id_rd}, 32'd0);
      check("rst_imm", id_imm, 32'd0);
      check("rst_rw", {31'b0, id_reg_write}, 32'd0);
      check("rst_ready", {31'b0, id_ready}, 32'd1);
      rst_n = 1'b1;

      // Back-to-back decode vectors; each replaces the previous with no bubble
      ex_ready = 1'b1;
      for (int i = 0; i < 13; i++) begin
         if_valid = 1'b1; if_instr = vecs[i].instr; if_pc = vecs[i].pc;
         #1;
         check($sformatf("v%0d_ready", i), {31'b0, id_ready}, 32'd1);
         step();
         check($sformatf("v%0d_valid", i), {31'b0, id_valid}, 32'd1);
         check($sformatf("v%0d_pc", i), id_pc, vecs[i].pc);
         check($sformatf("v%0d_op", i), {28'b0, id_op}, {28'b0, vecs[i].op});
         check($sformatf("v%0d_rs1", i), {27'b0, id_rs1}, {27'b0, vecs[i].rs1});
         check($sformatf("v%0d_rs2", i), {27'b0, id_rs2}, {27'b0, vecs[i].rs2});
         check($sformatf("v%0d_rd", i), {27'b0, id_rd}, {27'b0, vecs[i].rd});
         check($sformatf("v%0d_imm", i), id_imm, vecs[i].imm);
         check($sformatf("v%0d_rw", i), {31'b0, id_reg_write}, {31'b0, vecs[i].rw});
         check($sformatf("v%0d_ill", i), {31'b0, id_illegal}, {31'b0, vecs[i].ill});
      end

      // Backpressure: three cycles of ex_ready low keep outputs stable
      if_valid = 1'b1; if_instr = 32'h00228333; if_pc = 32'h2000; ex_ready = 1'b1;
      step();
      ex_ready = 1'b0; if_instr = 32'h00708293; if_pc = 32'h2004;
      #1;
      check("bp_ready0", {31'b0, id_ready}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         check($sformatf("bp%0d_valid", i), {31'b0, id_valid}, 32'd1);
         check($sformatf("bp%0d_pc", i), id_pc, 32'h2000);
         check($sformatf("bp%0d_rd", i), {27'b0, id_rd}, 32'd6);
         check($sformatf("bp%0d_op", i), {28'b0, id_op}, 32'd0);
         check($sformatf("bp%0d_ready", i), {31'b0, id_ready}, 32'd0);
      end
      ex_ready = 1'b1;
      #1;
      check("bp_release_ready", {31'b0, id_ready}, 32'd1);
      step();
      check("bp_next_pc", id_pc, 32'h2004);
      check("bp_next_op", {28'b0, id_op}, 32'd1);

      // Flush together with an offered instruction
      flush = 1'b1; if_valid = 1'b1; if_instr = 32'hFE21AE23; if_pc = 32'h2008;
      #1;
      check("fl_ready", {31'b0, id_ready}, 32'd0);
      step();
      flush = 1'b0; if_valid = 1'b0;
      #1;
      check("fl_valid", {31'b0, id_valid}, 32'd0);
      check("fl_pc_kept", id_pc, 32'h2004);
      check("fl_ready_after", {31'b0, id_ready}, 32'd1);

      // Load-use on rs1 of held add x6,x5,x2
      if_valid = 1'b1; if_instr = 32'h00228333; if_pc = 32'h3000; ex_ready = 1'b1;
      step();
      if_valid = 1'b0; ex_ready = 1'b0; ex_is_load = 1'b1; ex_rd = 5'd5;
      #1;
      check("st_valid", {31'b0, id_valid}, {31'b0, !StallEn});
      check("st_ready", {31'b0, id_ready}, 32'd0);
      step(); step();
      check("st_hold_valid", {31'b0, id_valid}, {31'b0, !StallEn});
      check("st_hold_pc", id_pc, 32'h3000);
      ex_is_load = 1'b0;
      #1;
      check("st_resume_valid", {31'b0, id_valid}, 32'd1);
      check("st_resume_pc", id_pc, 32'h3000);
      check("st_resume_rd", {27'b0, id_rd}, 32'd6);
      check("st_resume_rs1", {27'b0, id_rs1}, 32'd5);
      check("st_resume_rs2", {27'b0, id_rs2}, 32'd2);

      // Load-use on rs2, with ex_ready high: stall must also block hand-off
      ex_is_load = 1'b1; ex_rd = 5'd2; ex_ready = 1'b1;
      #1;
      check("st2_valid", {31'b0, id_valid}, {31'b0, !StallEn});
      check("st2_ready", {31'b0, id_ready}, {31'b0, !StallEn});

      // Reset during the stall
      rst_n = 1'b0; ex_ready = 1'b0;
      step();
      check("rs_valid", {31'b0, id_valid}, 32'd0);
      check("rs_pc", id_pc, NopPc);
      check("rs_rd", {27'b0, id_rd}, 32'd0);
      check("rs_rs1", {27'b0, id_rs1}, 32'd0);
      check("rs_imm", id_imm, 32'd0);
      check("rs_op", {28'b0, id_op}, 32'd0);
      check("rs_rw", {31'b0, id_reg_write}, 32'd0);
      rst_n = 1'b1;
      #1;
      check("rs_ready", {31'b0, id_ready}, 32'd1);

      // rs2 field of an I-type is not a real operand: no stall
      ex_is_load = 1'b0; ex_ready = 1'b1;
      if_valid = 1'b1; if_instr = 32'h00708293; if_pc = 32'h4000;
      step();
      if_valid = 1'b0; ex_ready = 1'b0; ex_is_load = 1'b1; ex_rd = 5'd7;
      #1;
      check("nost_valid", {31'b0, id_valid}, 32'd1);
      ex_rd = 5'd1;
      #1;
      check("st3_valid", {31'b0, id_valid}, {31'b0, !StallEn});
      ex_is_load = 1'b0;
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
